// File: rtl/puf_axil_regs.sv
// rtl/puf_axil_regs.sv - AXI4-Lite register front-end for the inverter PUF core
//
// Purpose: four 32-bit registers (CTRL, CHALLENGE, RESPONSE, STATUS) behind an
// AXI4-Lite responder. Issues a one-cycle start pulse to the PUF core and
// latches its response when the core signals completion.
//
// Optional build macro: PUF_IRQ_EN adds the irq output and CTRL.IRQ_EN.
//
// Ports:
//   s00_axi_aclk / s00_axi_areset   clock, synchronous active-high reset
//   s00_axi_aw* / s00_axi_w* / s00_axi_b*   write address, data, response
//   s00_axi_ar* / s00_axi_r*                read address, data
//   puf_start      one-cycle start pulse to the core
//   puf_challenge  CHALLENGE register contents
//   puf_busy       core evaluation in progress (live into STATUS.BUSY)
//   puf_done       one-cycle completion pulse, qualifies puf_response
//   puf_response   core result, zero-extended into RESPONSE
//   irq            VALID & IRQ_EN, registered (PUF_IRQ_EN builds only)

module puf_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int RESP_WIDTH         = 32
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            puf_start,
  output logic [31:0]                     puf_challenge,
  input  logic                            puf_busy,
  input  logic                            puf_done,
  input  logic [RESP_WIDTH-1:0]           puf_response
`ifdef PUF_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHAL = 2'd1;
  localparam logic [1:0] REG_RESP = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // ------------------------------------------------------------------
  // Register state
  // ------------------------------------------------------------------
  logic [31:0] chal_q;
  logic [31:0] resp_q;
  logic        valid_q;
  logic        overrun_q;
  logic        start_q;
`ifdef PUF_IRQ_EN
  logic        irq_en_q;
  logic        irq_q;
`endif

  // ------------------------------------------------------------------
  // Write channel state
  // ------------------------------------------------------------------
  w_state_t    w_state_q, w_state_d;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic [1:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        aw_hs;
  logic        w_hs;
  logic        wr_commit;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  // ------------------------------------------------------------------
  // Read channel state
  // ------------------------------------------------------------------
  r_state_t    r_state_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;
  logic [31:0] resp_ext;
  logic [31:0] ctrl_rd;

  // Address low bits and protection are don't-cares on this bus.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs = s00_axi_awvalid & awready_q;
  assign w_hs  = s00_axi_wvalid  & wready_q;

  // Next state plus the commit bundle. A commit happens on any transition
  // into W_RESP; the address/data come from the bus or from the captured
  // half, whichever arrived earlier.
  always_comb begin
    w_state_d = w_state_q;
    wr_commit = 1'b0;
    wr_idx    = aw_idx_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
          wr_idx    = s00_axi_awaddr[3:2];
          wr_data   = s00_axi_wdata;
          wr_strb   = s00_axi_wstrb;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          wr_commit = 1'b1;
          wr_data   = s00_axi_wdata;
          wr_strb   = s00_axi_wstrb;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          wr_commit = 1'b1;
          wr_idx    = s00_axi_awaddr[3:2];
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_q && s00_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Readies are registered from the next state so they are low through
  // reset and rise on the first edge after reset is released.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= 2'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
      wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
      if (w_state_q == W_IDLE && aw_hs) begin
        aw_idx_q <= s00_axi_awaddr[3:2];
      end
      if (w_state_q == W_IDLE && w_hs) begin
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_idx == REG_RESP) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
        bresp_q  <= RESP_OKAY;
      end
    end
  end

  always_comb begin
    resp_ext = '0;
    resp_ext[RESP_WIDTH-1:0] = puf_response;
  end

  // Register file. puf_done is applied last so a completion wins over a
  // same-cycle VALID clear (W1C or START).
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      chal_q    <= 32'd0;
      resp_q    <= 32'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      start_q   <= 1'b0;
`ifdef PUF_IRQ_EN
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      if (wr_commit) begin
        case (wr_idx)
          REG_CTRL: begin
            if (wr_strb[0]) begin
              if (wr_data[0]) begin
                if (!puf_busy) begin
                  start_q <= 1'b1;
                  valid_q <= 1'b0;
                end else begin
                  overrun_q <= 1'b1;
                end
              end
`ifdef PUF_IRQ_EN
              irq_en_q <= wr_data[1];
`endif
            end
          end
          REG_CHAL: begin
            for (int b = 0; b < 4; b++) begin
              if (wr_strb[b]) begin
                chal_q[8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
          end
          REG_STAT: begin
            if (wr_strb[0]) begin
              if (wr_data[1]) valid_q   <= 1'b0;
              if (wr_data[2]) overrun_q <= 1'b0;
            end
          end
          default: begin
            // RESPONSE is read-only; the write is refused with SLVERR.
          end
        endcase
      end
      if (puf_done) begin
        resp_q  <= resp_ext;
        valid_q <= 1'b1;
      end
`ifdef PUF_IRQ_EN
      irq_q <= valid_q & irq_en_q;
`endif
    end
  end

`ifdef PUF_IRQ_EN
  assign ctrl_rd = {30'd0, irq_en_q, 1'b0};
`else
  assign ctrl_rd = 32'd0;
`endif

  // Read data is taken from the current (pre-commit) register values.
  always_comb begin
    rd_mux = 32'd0;
    case (s00_axi_araddr[3:2])
      REG_CTRL: rd_mux = ctrl_rd;
      REG_CHAL: rd_mux = chal_q;
      REG_RESP: rd_mux = resp_q;
      REG_STAT: rd_mux = {29'd0, overrun_q, valid_q, puf_busy};
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s00_axi_arvalid && arready_q) begin
            rdata_q   <= rd_mux;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = RESP_OKAY;
  assign puf_start       = start_q;
  assign puf_challenge   = chal_q;
`ifdef PUF_IRQ_EN
  assign irq             = irq_q;
`endif

endmodule

// File: tb/tb_puf_axil_regs.sv
// tb/tb_puf_axil_regs.sv - scoreboard bench for puf_axil_regs

module tb_puf_axil_regs;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        puf_start, puf_busy, puf_done;
  logic [31:0] puf_challenge, puf_response;
`ifdef PUF_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  puf_axil_regs dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .puf_start(puf_start), .puf_challenge(puf_challenge),
    .puf_busy(puf_busy), .puf_done(puf_done), .puf_response(puf_response)
`ifdef PUF_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int b_seen = 0;
  int r_seen = 0;
  int start_cnt = 0;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops the expected response whenever a B or R handshake is seen.
  initial forever begin
    @(negedge clk);
    if (bvalid === 1'b1 && bready === 1'b1) begin
      if (bq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_b: got bresp=%0d expected no response", bresp);
      end else begin
        chk("bresp", {30'd0, bresp}, {30'd0, bq.pop_front()});
      end
      b_seen++;
    end
    if (rvalid === 1'b1 && rready === 1'b1) begin
      if (rq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_r: got rdata=0x%08h expected no response", rdata);
      end else begin
        chk("rdata", rdata, rq.pop_front());
        chk("rresp", {30'd0, rresp}, 32'd0);
      end
      r_seen++;
    end
    if (puf_start === 1'b1) start_cnt++;
  end

  task automatic aw_w_phase(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, af, wf;
    int k = 0;
    while (!(aw_done && w_done) && k < 60) begin
      if (!aw_done && k >= aw_dly) begin awaddr = a; awvalid = 1'b1; end
      if (!w_done && k >= w_dly) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      @(negedge clk);
      af = awvalid & awready;
      wf = wvalid & wready;
      @(posedge clk); #1;
      if (af) begin awvalid = 1'b0; aw_done = 1; end
      if (wf) begin wvalid = 1'b0; w_done = 1; end
      k++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_accept", {31'd0, aw_done & w_done}, 32'd1);
  endtask

  task automatic wait_b(input int tgt);
    int k = 0;
    while (b_seen < tgt && k < 50) begin @(posedge clk); #1; k++; end
    chk("b_arrived", {31'd0, b_seen >= tgt}, 32'd1);
  endtask

  task automatic wait_r(input int tgt);
    int k = 0;
    while (r_seen < tgt && k < 50) begin @(posedge clk); #1; k++; end
    chk("r_arrived", {31'd0, r_seen >= tgt}, 32'd1);
  endtask

  task automatic axi_write_d(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input int aw_dly, input int w_dly);
    int tgt = b_seen + 1;
    bq.push_back(er);
    aw_w_phase(a, d, s, aw_dly, w_dly);
    wait_b(tgt);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er);
    axi_write_d(a, d, s, er, 0, 0);
  endtask

  task automatic ar_phase(input logic [3:0] a);
    bit done = 0, af;
    int k = 0;
    araddr = a; arvalid = 1'b1;
    while (!done && k < 50) begin
      @(negedge clk);
      af = arvalid & arready;
      @(posedge clk); #1;
      if (af) begin arvalid = 1'b0; done = 1; end
      k++;
    end
    arvalid = 1'b0;
    chk("ar_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] e);
    int tgt = r_seen + 1;
    rq.push_back(e);
    ar_phase(a);
    wait_r(tgt);
  endtask

  task automatic puf_complete(input logic [31:0] r);
    puf_response = r; puf_done = 1'b1;
    @(posedge clk); #1;
    puf_done = 1'b0; puf_response = 32'd0;
  endtask

  initial begin
    int tgt;
    areset = 1'b1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 1'b1;
    arvalid = 0; rready = 1'b1; puf_busy = 0; puf_done = 0; puf_response = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_start", {31'd0, puf_start}, 32'd0);
    chk("rst_chal", puf_challenge, 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    axi_read(4'hC, 32'h0);
    axi_read(4'h8, 32'h0);

    // 1: CHALLENGE full write then byte-lane write
    axi_write(4'h4, 32'hA5A5_1234, 4'hF, 2'b00);
    chk("puf_challenge", puf_challenge, 32'hA5A5_1234);
    axi_read(4'h4, 32'hA5A5_1234);
    axi_write(4'h5, 32'hFFFF_FFFF, 4'h2, 2'b00);
    axi_read(4'h4, 32'hA5A5_FF34);

    // 2: AW leads W by 3, W leads AW by 2, then held bready
    axi_write_d(4'h4, 32'h1122_3344, 4'hF, 2'b00, 0, 3);
    axi_read(4'h4, 32'h1122_3344);
    axi_write_d(4'h4, 32'h5566_7788, 4'hF, 2'b00, 2, 0);
    axi_read(4'h4, 32'h5566_7788);
    bready = 1'b0;
    tgt = b_seen + 1;
    bq.push_back(2'b00);
    aw_w_phase(4'h4, 32'h0BAD_F00D, 4'hF, 0, 0);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 4'h4; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk("hold_bvalid", {31'd0, bvalid}, 32'd1);
      chk("hold_readies", {30'd0, awready, wready}, 32'd0);
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    wait_b(tgt);
    axi_read(4'h4, 32'h0BAD_F00D);

    // 3: START while idle, then completion
    axi_write(4'h0, 32'h1, 4'hF, 2'b00);
    chk("start_pulses", start_cnt, 32'd1);
    axi_read(4'hC, 32'h0);
    puf_complete(32'hDEAD_BEEF);
    axi_read(4'h8, 32'hDEAD_BEEF);
    axi_read(4'hC, 32'h2);
    axi_write(4'hC, 32'h2, 4'h1, 2'b00);
    axi_read(4'hC, 32'h0);

    // 4: START while busy -> OVERRUN, then W1C of OVERRUN
    puf_busy = 1'b1;
    axi_write(4'h0, 32'h1, 4'hF, 2'b00);
    chk("no_start_busy", start_cnt, 32'd1);
    axi_read(4'hC, 32'h5);
    axi_write(4'hC, 32'h4, 4'hF, 2'b00);
    axi_read(4'hC, 32'h1);
    puf_busy = 1'b0;

    // 5: RESPONSE write refused; CTRL reads 0 after START; rready held
    axi_write(4'h8, 32'h1, 4'hF, 2'b10);
    axi_read(4'h8, 32'hDEAD_BEEF);
    axi_write(4'h0, 32'h1, 4'hF, 2'b00);
    chk("start_pulses2", start_cnt, 32'd2);
    axi_read(4'h0, 32'h0);
    rready = 1'b0;
    tgt = r_seen + 1;
    rq.push_back(32'hDEAD_BEEF);
    ar_phase(4'h8);
    for (int i = 0; i < 3; i++) begin
      chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
      chk("hold_rdata", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_r(tgt);

    // 6: interrupt
`ifdef PUF_IRQ_EN
    axi_write(4'h0, 32'h2, 4'hF, 2'b00);
    axi_read(4'h0, 32'h2);
    axi_write(4'h0, 32'h3, 4'hF, 2'b00);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    puf_complete(32'h0000_00A5);
    chk("irq_with_valid", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", {31'd0, irq}, 32'd1);
    axi_write(4'hC, 32'h2, 4'hF, 2'b00);
    chk("irq_fall", {31'd0, irq}, 32'd0);
`else
    axi_write(4'h0, 32'h2, 4'hF, 2'b00);
    axi_read(4'h0, 32'h0);
`endif

    repeat (3) @(posedge clk);
    chk("bq_empty", bq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/puf_axil_regs.md
Name: puf_axil_regs

Overview:
- AXI4-Lite responder (slave) exposing the inverter PUF core to a bus master. It is the target side of the AXI4-Lite master traffic used in the block-level bench.
- Decodes four 32-bit registers: CTRL, CHALLENGE, RESPONSE and STATUS.
- Issues a one-cycle start pulse to the PUF core and latches the core's response on completion.
- Independent write and read channel FSMs; one outstanding transaction per direction.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- RESP_WIDTH, 32, PUF response width, 1..32; RESPONSE is zero-extended to 32 bits.

Ports:
- s00_axi_aclk in 1: single clock.
- s00_axi_areset in 1: synchronous reset, active-high.
- s00_axi_awaddr in 4: write address.
- s00_axi_awprot in 3: write protection; ignored.
- s00_axi_awvalid in 1 / s00_axi_awready out 1: write address handshake.
- s00_axi_wdata in 32: write data.
- s00_axi_wstrb in 4: write byte strobes.
- s00_axi_wvalid in 1 / s00_axi_wready out 1: write data handshake.
- s00_axi_bresp out 2: write response code.
- s00_axi_bvalid out 1 / s00_axi_bready in 1: write response handshake.
- s00_axi_araddr in 4: read address.
- s00_axi_arprot in 3: read protection; ignored.
- s00_axi_arvalid in 1 / s00_axi_arready out 1: read address handshake.
- s00_axi_rdata out 32: read data.
- s00_axi_rresp out 2: read response code.
- s00_axi_rvalid out 1 / s00_axi_rready in 1: read data handshake.
- puf_start out 1: one-cycle start pulse to the PUF core.
- puf_challenge out 32: CHALLENGE register contents.
- puf_busy in 1: PUF core evaluation in progress.
- puf_done in 1: one-cycle completion pulse from the PUF core.
- puf_response in RESP_WIDTH: PUF result, valid only while puf_done=1.
- irq out 1: interrupt; present only with PUF_IRQ_EN.

Behaviour:

Register map:
- 0x0 CTRL:
  - bit0 START: write-1 pulses puf_start; self-clearing; always reads 0.
  - bit1 IRQ_EN: read/write.
- 0x4 CHALLENGE: read/write; wstrb byte lanes honoured.
- 0x8 RESPONSE: read-only; a write returns BRESP=SLVERR (2'b10) with no state change.
- 0xC STATUS:
  - bit0 BUSY: live copy of puf_busy.
  - bit1 VALID: sticky.
  - bit2 OVERRUN: sticky.
  - bits 1 and 2 are write-1-to-clear; bit0 writes are ignored.
- CTRL and STATUS writes act only when wstrb[0]=1.

Reset:
- All of the following are 0: awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, puf_start, puf_challenge, RESPONSE, STATUS bits, IRQ_EN, irq.
- Both FSMs return to IDLE.
- Reset mid-transaction aborts it with no response issued.

Write FSM:
- States: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
- awready is 1 in W_IDLE and W_HAVE_DATA.
- wready is 1 in W_IDLE and W_HAVE_ADDR.
- Readies are registered: both low while in reset, high in the first cycle after reset deasserts.
- AW and W accepted in the same cycle: go directly W_IDLE→W_RESP.
- Otherwise the captured half is held and the FSM waits for the other half.
- The register update commits on the clock edge entering W_RESP.
- bvalid=1 in W_RESP, with bresp OKAY or SLVERR; held until bready; then return to W_IDLE.
- Minimum latency: bvalid 1 cycle after the completing handshake.

Read FSM:
- States: R_IDLE (arready=1) and R_DATA.
- On the AR handshake: rdata is registered from the selected register and rvalid=1 on the next cycle, held stable until rready.
- rresp is always OKAY.
- Returns to R_IDLE after the rready handshake.
- Reads and writes proceed concurrently. A read in the same cycle as a write commit to the same register returns the pre-write value.

START handling:
- START with puf_busy=0: puf_start=1 for exactly one cycle, the cycle after the write commit. VALID clears in the same cycle.
- START with puf_busy=1: no pulse; OVERRUN is set.

Completion:
- puf_done=1 latches puf_response (zero-extended) into RESPONSE and sets VALID.
- puf_done and a VALID W1C write in the same cycle: the set wins, VALID stays 1.

Optional Feature:
- Macro: PUF_IRQ_EN.
- Defined:
  - irq is registered as VALID & IRQ_EN.
  - irq asserts 1 cycle after VALID rises and deasserts 1 cycle after VALID clears.
- Undefined:
  - irq port is absent.
  - CTRL bit1 is not implemented and reads 0.

Test Plan:
1. Reset, then write CHALLENGE=0xA5A5_1234 with wstrb=0xF → bresp=OKAY, puf_challenge=0xA5A5_1234, readback 0xA5A5_1234. Then write 0xFFFF_FFFF with wstrb=0x2 → readback 0xA5A5_FF34.
2. AW presented 3 cycles before W, then W presented 2 cycles before AW → each completes with exactly one bvalid and a correct register update. Hold bready=0 for 4 cycles → bvalid stays high, no new AW/W accepted.
3. Write CTRL=0x1 with puf_busy=0 → single-cycle puf_start; STATUS=0x0. Model pulses puf_done with puf_response=0xDEAD_BEEF → RESPONSE=0xDEAD_BEEF, STATUS=0x2.
4. Write CTRL=0x1 while puf_busy=1 → no puf_start, STATUS=0x5. Write STATUS=0x4 → STATUS=0x1.
5. Write 0x8 with data 0x1 → bresp=SLVERR, RESPONSE unchanged. Read 0x0 after START → 0x0. Hold rready=0 for 3 cycles → rdata stable.
6. With PUF_IRQ_EN: write CTRL=0x2, START, then puf_done → irq=1 one cycle after VALID. Write STATUS=0x2 → irq=0 the cycle after.
